// File: rtl/relogio_pkg.sv
// relogio_pkg: mode encodings and default timing shared by the clock controller and display.
package relogio_pkg;
    localparam logic [1:0] MODE_RUN      = 2'b00;
    localparam logic [1:0] MODE_SET_HORA = 2'b01;
    localparam logic [1:0] MODE_SET_MIN  = 2'b10;
    localparam longint unsigned TICKS_PER_MIN_DEF = 64'd3_000_000_000;
    localparam int unsigned HOLD_CYC_DEF   = 25_000_000;
    localparam int unsigned REPEAT_CYC_DEF = 5_000_000;
    localparam int unsigned BLINK_CYC_DEF  = 12_500_000;
    typedef enum logic [1:0] {
        ST_RUN      = MODE_RUN,
        ST_SET_HORA = MODE_SET_HORA,
        ST_SET_MIN  = MODE_SET_MIN
    } state_t;
endpackage

// File: rtl/relogio_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer with rising-edge press pulse.
// A button already high when reset ends stays masked until it is seen released.
module btn_sync_edge (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);
    logic [1:0] r_sync;
    logic [1:0] r_fill;
    logic       r_prev;
    logic       r_armed;
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_i};
            r_fill  <= {r_fill[0], 1'b1};
            r_prev  <= r_sync[1];
            r_armed <= r_armed | (r_fill[1] & ~r_sync[1]);
        end
    end
    assign level_o = r_sync[1] & r_armed;
    assign press_o = level_o & ~r_prev;
endmodule

// File: rtl/relogio_ctrl.sv
// relogio_ctrl: RUN/SET mode sequencer for the clock, generating minute ticks and set pulses.
module relogio_ctrl
    import relogio_pkg::*;
#(
    parameter longint unsigned TICKS_PER_MIN = TICKS_PER_MIN_DEF,
    parameter int unsigned     CNT_W         = 32,
    parameter int unsigned     HOLD_CYC      = HOLD_CYC_DEF,
    parameter int unsigned     REPEAT_CYC    = REPEAT_CYC_DEF,
    parameter int unsigned     BLINK_CYC     = BLINK_CYC_DEF
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    output logic       inc_min_o,
    output logic       inc_hora_o,
    output logic       carry_mask_o,
    output logic [1:0] mode_o,
    output logic       blink_o
);
    localparam int HOLD_W  = $clog2(HOLD_CYC + REPEAT_CYC + 1);
    localparam int BLINK_W = $clog2(BLINK_CYC + 1);
    localparam logic [CNT_W-1:0]   PRESC_MAX   = CNT_W'(TICKS_PER_MIN - 1);
    localparam logic [HOLD_W-1:0]  HOLD_FIRE   = HOLD_W'(HOLD_CYC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_WRAP   = HOLD_W'(HOLD_CYC + REPEAT_CYC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(HOLD_CYC);
    localparam logic [BLINK_W-1:0] BLINK_MAX   = BLINK_W'(BLINK_CYC - 1);

    logic w_mode_press, w_mode_level, w_inc_press, w_inc_level;
    logic w_set, w_tick, w_rep, w_fire;
    state_t w_next_state;

    state_t             r_state;
    logic [CNT_W-1:0]   r_presc;
    logic [HOLD_W-1:0]  r_hold;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_inc_min, r_inc_hora, r_carry_mask, r_blink;

    btn_sync_edge u_mode (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .btn_i  (btn_mode_i),
        .level_o(w_mode_level),
        .press_o(w_mode_press)
    );

    btn_sync_edge u_inc (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .btn_i  (btn_inc_i),
        .level_o(w_inc_level),
        .press_o(w_inc_press)
    );

    // Set pulses are suppressed while any pulse is out so the counters always see a low gap.
    always_comb begin
        w_set        = r_state != ST_RUN;
        w_next_state = r_state == ST_RUN ? ST_SET_HORA : r_state == ST_SET_HORA ? ST_SET_MIN : ST_RUN;
        w_tick       = r_state == ST_RUN && r_presc == PRESC_MAX;
        w_rep        = w_inc_level && (r_hold == HOLD_FIRE || r_hold == HOLD_WRAP);
        w_fire       = w_set && !w_mode_press && (w_inc_press || w_rep) && !r_inc_min && !r_inc_hora;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state      <= ST_RUN;
            r_presc      <= '0;
            r_hold       <= '0;
            r_blink_cnt  <= '0;
            r_inc_min    <= 1'b0;
            r_inc_hora   <= 1'b0;
            r_carry_mask <= 1'b0;
            r_blink      <= 1'b0;
        end else begin
            r_presc    <= (w_tick || w_set || w_mode_press) ? '0 : r_presc + CNT_W'(1);
            r_hold     <= (w_set && w_inc_level && !w_mode_press) ?
                          (r_hold == HOLD_WRAP ? HOLD_RELOAD : r_hold + HOLD_W'(1)) : '0;
            r_inc_min  <= w_tick || (w_fire && r_state == ST_SET_MIN);
            r_inc_hora <= w_fire && r_state == ST_SET_HORA;
            if (w_mode_press) begin
                r_state      <= w_next_state;
                r_carry_mask <= w_next_state == ST_SET_MIN;
                r_blink      <= w_next_state != ST_RUN;
                r_blink_cnt  <= '0;
            end else if (w_set) begin
                r_blink_cnt <= r_blink_cnt == BLINK_MAX ? '0 : r_blink_cnt + BLINK_W'(1);
                r_blink     <= r_blink_cnt == BLINK_MAX ? ~r_blink : r_blink;
            end
        end
    end

    assign inc_min_o    = r_inc_min;
    assign inc_hora_o   = r_inc_hora;
    assign carry_mask_o = r_carry_mask;
    assign mode_o       = r_state;
    assign blink_o      = r_blink;
endmodule
